regfile_pp: RTL and testbench

Double-buffered (ping-pong) operand register file for the S-tile vector FU. Upstream channels each deliver one vector over a valid/ready handshake, and a config channel delivers one config word. When every slot of a bank is filled, that bank is handed to the read side as one operand set. Meanwhile the writers fill the other bank. A bank is released back to the writers only after every read port has signalled completion, so writes and reads overlap without corrupting in-use operands.

---
 rtl/regfile_pp_pkg.sv | 20 ++
 rtl/regfile_pp_bank.sv | 47 ++++
 rtl/regfile_pp.sv | 123 ++++++++++++
 tb/tb_regfile_pp.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pp_pkg.sv
// Shared types and constants for the ping-pong operand register file.
// Default geometry lives here; the modules carry matching overridable parameters.
package regfile_pp_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefLanes = 4;
  localparam int unsigned DefWch   = 2;
  localparam int unsigned DefRd    = 2;

  typedef logic bsel_t;

  typedef logic [DefWidth-1:0] word_t;
  typedef word_t [DefLanes-1:0] vec_t;

  // One slot per vector write channel plus one for the config word.
  function automatic int unsigned num_slots(input int unsigned nwch);
    return nwch + 1;
  endfunction

endpackage

// File: rtl/regfile_pp_bank.sv
// One operand bank: per-channel vector storage, a config slot and the slot valid mask.
// all_valid reports that the mask would be all-ones after this cycle's writes.
module regfile_pp_bank
  import regfile_pp_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned NUM_LANES = DefLanes,
  parameter int unsigned NUM_WCH   = DefWch
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_WCH:0]                              wen,
  input  logic [NUM_WCH-1:0][NUM_LANES-1:0][WIDTH-1:0]  wdata,
  input  logic [WIDTH-1:0]                              cfg_wdata,
  input  logic                                          clear,
  output logic [NUM_WCH:0]                              mask,
  output logic                                          all_valid,
  output logic [NUM_WCH*NUM_LANES:0][WIDTH-1:0]         rdata
);

  localparam int unsigned NumSlots = num_slots(NUM_WCH);

  logic [NUM_WCH-1:0][NUM_LANES-1:0][WIDTH-1:0] ch_q;
  logic [WIDTH-1:0]                             cfg_q;
  logic [NumSlots-1:0]                          mask_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_q   <= '0;
      cfg_q  <= '0;
      mask_q <= '0;
    end else begin
      // Data is still captured on the completing edge; only the mask is cleared.
      if (clear) mask_q <= '0;
      else       mask_q <= mask_q | wen;
      for (int unsigned c = 0; c < NUM_WCH; c++) begin
        if (wen[c]) ch_q[c] <= wdata[c];
      end
      if (wen[NUM_WCH]) cfg_q <= cfg_wdata;
    end
  end

  assign mask      = mask_q;
  assign all_valid = &(mask_q | wen);
  assign rdata     = {cfg_q, ch_q};

endmodule

// File: rtl/regfile_pp.sv
// Double-buffered operand register file: writers fill one bank while readers drain the other.
// Define REGFILE_PP_CFG_STICKY_EN to hold config in a shadow register copied into each bank.
module regfile_pp
  import regfile_pp_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned NUM_LANES = DefLanes,
  parameter int unsigned NUM_WCH   = DefWch,
  parameter int unsigned NUM_RD    = DefRd
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_WCH-1:0]                            w_vld,
  input  logic [NUM_WCH-1:0][NUM_LANES-1:0][WIDTH-1:0]  w_data,
  output logic [NUM_WCH-1:0]                            w_rdy,
  input  logic                                          cfg_vld,
  input  logic [WIDTH-1:0]                              cfg_data,
  output logic                                          cfg_rdy,
  output logic [NUM_WCH*NUM_LANES:0][WIDTH-1:0]         r_data,
  output logic [NUM_RD-1:0]                             r_vld,
  input  logic [NUM_RD-1:0]                             r_done,
  output logic [1:0]                                    bank_full
);

  localparam int unsigned NumSlots = num_slots(NUM_WCH);
  localparam int unsigned NumWords = NUM_WCH * NUM_LANES + 1;

  logic              run_q;
  logic [1:0]        full_q, full_d;
  bsel_t             wsel_q, rsel_q;
  logic [NUM_RD-1:0] done_seen_q, done_acc;

  logic [1:0][NumSlots-1:0]            bank_wen, bank_mask;
  logic [1:0]                          bank_all, wsel_oh;
  logic [1:0][NumWords-1:0][WIDTH-1:0] bank_rdata;

  logic [NumSlots-1:0] wen, wmask;
  logic [WIDTH-1:0]    cfg_slot;
  logic                wr_open, complete, drain_done;

  assign wsel_oh = {wsel_q, ~wsel_q};
  assign wmask   = bank_mask[wsel_q];
  // run_q keeps every ready low while in reset without a reset-to-ready combinational path.
  assign wr_open = run_q & ~full_q[wsel_q];

  assign w_rdy              = {NUM_WCH{wr_open}} & ~wmask[NUM_WCH-1:0];
  assign wen[NUM_WCH-1:0]   = w_vld & w_rdy;

`ifdef REGFILE_PP_CFG_STICKY_EN
  logic [WIDTH-1:0] shadow_q;
  logic             shadow_vld_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
    end else if (cfg_vld && cfg_rdy) begin
      shadow_q     <= cfg_data;
      shadow_vld_q <= 1'b1;
    end
  end

  // The config slot tracks the shadow, so it holds the shadow value at completion.
  assign cfg_rdy      = run_q;
  assign wen[NUM_WCH] = wr_open & shadow_vld_q;
  assign cfg_slot     = shadow_q;
`else
  assign cfg_rdy      = wr_open & ~wmask[NUM_WCH];
  assign wen[NUM_WCH] = cfg_vld & cfg_rdy;
  assign cfg_slot     = cfg_data;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wen[b] = wsel_oh[b] ? wen : '0;

    regfile_pp_bank #(
      .WIDTH    (WIDTH),
      .NUM_LANES(NUM_LANES),
      .NUM_WCH  (NUM_WCH)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wen      (bank_wen[b]),
      .wdata    (w_data),
      .cfg_wdata(cfg_slot),
      .clear    (wsel_oh[b] & complete),
      .mask     (bank_mask[b]),
      .all_valid(bank_all[b]),
      .rdata    (bank_rdata[b])
    );
  end

  assign complete   = bank_all[wsel_q];
  assign r_vld      = {NUM_RD{full_q[rsel_q]}} & ~done_seen_q;
  assign done_acc   = r_done & r_vld;
  assign drain_done = full_q[rsel_q] & (&(done_seen_q | done_acc));
  assign r_data     = full_q[rsel_q] ? bank_rdata[rsel_q] : '0;
  assign bank_full  = full_q;

  // Completion needs an empty write bank and release a full read bank, so they never collide.
  always_comb begin
    full_d = full_q;
    if (complete)   full_d[wsel_q] = 1'b1;
    if (drain_done) full_d[rsel_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q       <= 1'b0;
      full_q      <= '0;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      done_seen_q <= '0;
    end else begin
      run_q  <= 1'b1;
      full_q <= full_d;
      if (complete)   wsel_q <= ~wsel_q;
      if (drain_done) rsel_q <= ~rsel_q;
      done_seen_q <= drain_done ? '0 : (done_seen_q | done_acc);
    end
  end

endmodule

// File: tb/tb_regfile_pp.sv
// Directed bench for regfile_pp: fill, partial drain, back-pressure, staggered writes, reset.
module tb_regfile_pp;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [1:0]              w_vld;
  logic [1:0][3:0][15:0]   w_data;
  logic [1:0]              w_rdy;
  logic                    cfg_vld;
  logic [15:0]             cfg_data;
  logic                    cfg_rdy;
  logic [8:0][15:0]        r_data;
  logic [1:0]              r_vld;
  logic [1:0]              r_done;
  logic [1:0]              bank_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_pp #(
    .WIDTH    (16),
    .NUM_LANES(4),
    .NUM_WCH  (2),
    .NUM_RD   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .w_vld    (w_vld),
    .w_data   (w_data),
    .w_rdy    (w_rdy),
    .cfg_vld  (cfg_vld),
    .cfg_data (cfg_data),
    .cfg_rdy  (cfg_rdy),
    .r_data   (r_data),
    .r_vld    (r_vld),
    .r_done   (r_done),
    .bank_full(bank_full)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel c lane l carries base + 4*c + l.
  function automatic logic [127:0] wv(input logic [15:0] base);
    logic [7:0][15:0] v;
    for (int k = 0; k < 8; k++) v[k] = base + 16'(k);
    return v;
  endfunction

  function automatic logic [143:0] mk(input logic [15:0] base, input logic [15:0] cfg);
    logic [8:0][15:0] v;
    for (int k = 0; k < 8; k++) v[k] = base + 16'(k);
    v[8] = cfg;
    return v;
  endfunction

  initial begin
    reset    = 1'b0;
    w_vld    = '0;
    w_data   = '0;
    cfg_vld  = 1'b0;
    cfg_data = '0;
    r_done   = '0;
    repeat (3) tick();
    chk("rst_w_rdy", 160'(w_rdy), 160'(2'b00));
    chk("rst_cfg_rdy", 160'(cfg_rdy), 160'(1'b0));
    chk("rst_r_vld", 160'(r_vld), 160'(2'b00));
    chk("rst_full", 160'(bank_full), 160'(2'b00));

    reset = 1'b1;
    tick();
    chk("post_rst_w_rdy", 160'(w_rdy), 160'(2'b11));
    chk("post_rst_cfg_rdy", 160'(cfg_rdy), 160'(1'b1));
    chk("post_rst_r_vld", 160'(r_vld), 160'(2'b00));
    chk("post_rst_full", 160'(bank_full), 160'(2'b00));
    chk("post_rst_r_data", 160'(r_data), 160'(0));

`ifndef REGFILE_PP_CFG_STICKY_EN
    // Single fill, all slots in one cycle
    w_data = wv(16'd1); cfg_data = 16'hA5; w_vld = 2'b11; cfg_vld = 1'b1;
    tick();
    w_vld = '0; cfg_vld = 1'b0;
    chk("fill_r_vld", 160'(r_vld), 160'(2'b11));
    chk("fill_full", 160'(bank_full), 160'(2'b01));
    chk("fill_r_data", 160'(r_data), 160'(mk(16'd1, 16'hA5)));
    chk("fill_w_rdy", 160'(w_rdy), 160'(2'b11));
    r_done = 2'b11;
    tick();
    r_done = '0;
    chk("rel_r_vld", 160'(r_vld), 160'(2'b00));
    chk("rel_full", 160'(bank_full), 160'(2'b00));
    chk("rel_r_data", 160'(r_data), 160'(0));

    // Partial done: second fill lands in bank 1
    w_data = wv(16'h20); cfg_data = 16'h5A; w_vld = 2'b11; cfg_vld = 1'b1;
    tick();
    w_vld = '0; cfg_vld = 1'b0;
    chk("pd_full", 160'(bank_full), 160'(2'b10));
    chk("pd_r_data", 160'(r_data), 160'(mk(16'h20, 16'h5A)));
    r_done = 2'b01;
    tick();
    r_done = '0;
    chk("pd_r_vld", 160'(r_vld), 160'(2'b10));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) r_done = 2'b01;  // repeat done on an already-done port is ignored
      tick();
      r_done = '0;
      chk("pd_wait_r_vld", 160'(r_vld), 160'(2'b10));
      chk("pd_wait_full", 160'(bank_full), 160'(2'b10));
    end
    r_done = 2'b10;
    tick();
    r_done = '0;
    chk("pd_rel_r_vld", 160'(r_vld), 160'(2'b00));
    chk("pd_rel_full", 160'(bank_full), 160'(2'b00));

    // Back-pressure: fill both banks, nothing drained
    w_data = wv(16'h100); cfg_data = 16'h11; w_vld = 2'b11; cfg_vld = 1'b1;
    tick();
    w_data = wv(16'h200); cfg_data = 16'h22;
    tick();
    chk("bp_full", 160'(bank_full), 160'(2'b11));
    chk("bp_w_rdy", 160'(w_rdy), 160'(2'b00));
    chk("bp_cfg_rdy", 160'(cfg_rdy), 160'(1'b0));
    chk("bp_r_data", 160'(r_data), 160'(mk(16'h100, 16'h11)));
    w_data = wv(16'h300); cfg_data = 16'h33;
    tick();
    chk("bp_hold_full", 160'(bank_full), 160'(2'b11));
    chk("bp_hold_r_data", 160'(r_data), 160'(mk(16'h100, 16'h11)));
    w_vld = '0; cfg_vld = 1'b0;
    r_done = 2'b11;
    tick();
    r_done = '0;
    chk("bp_rel_full", 160'(bank_full), 160'(2'b10));
    chk("bp_rel_w_rdy", 160'(w_rdy), 160'(2'b11));
    chk("bp_rel_cfg_rdy", 160'(cfg_rdy), 160'(1'b1));
    chk("bp_rel_r_vld", 160'(r_vld), 160'(2'b11));
    chk("bp_rel_r_data", 160'(r_data), 160'(mk(16'h200, 16'h22)));
    r_done = 2'b11;
    tick();
    r_done = '0;
    chk("bp_drain_full", 160'(bank_full), 160'(2'b00));

    // Staggered writes: ch1, then cfg, blocked ch1 repeat, then ch0
    w_data = wv(16'h40); cfg_data = 16'h77;
    tick(); tick();
    w_vld = 2'b10;
    tick();
    w_vld = '0;
    chk("stg_w_rdy", 160'(w_rdy), 160'(2'b01));
    chk("stg_r_vld_a", 160'(r_vld), 160'(2'b00));
    tick();
    cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    chk("stg_cfg_rdy", 160'(cfg_rdy), 160'(1'b0));
    chk("stg_r_vld_b", 160'(r_vld), 160'(2'b00));
    w_data = wv(16'h90); w_vld = 2'b10;
    tick();
    w_vld = '0;
    chk("stg_blk_r_vld", 160'(r_vld), 160'(2'b00));
    chk("stg_blk_w_rdy", 160'(w_rdy), 160'(2'b01));
    tick(); tick();
    w_data = wv(16'h40); w_vld = 2'b01;
    tick();
    w_vld = '0;
    chk("stg_r_vld", 160'(r_vld), 160'(2'b11));
    chk("stg_r_data", 160'(r_data), 160'(mk(16'h40, 16'h77)));
    r_done = 2'b11;
    tick();
    r_done = '0;

    // Reset mid-drain with both banks full
    w_data = wv(16'h500); cfg_data = 16'h55; w_vld = 2'b11; cfg_vld = 1'b1;
    tick(); tick();
    w_vld = '0; cfg_vld = 1'b0;
    chk("rmd_pre_r_vld", 160'(r_vld), 160'(2'b11));
    chk("rmd_pre_full", 160'(bank_full), 160'(2'b11));
    reset = 1'b0;
    tick();
    chk("rmd_r_vld", 160'(r_vld), 160'(2'b00));
    chk("rmd_r_data", 160'(r_data), 160'(0));
    chk("rmd_full", 160'(bank_full), 160'(2'b00));
    chk("rmd_w_rdy", 160'(w_rdy), 160'(2'b00));
    reset = 1'b1;
    tick();
    chk("rmd_after_w_rdy", 160'(w_rdy), 160'(2'b11));
    chk("rmd_after_full", 160'(bank_full), 160'(2'b00));
`else
    // Sticky config: one cfg write, then three fills without cfg
    cfg_data = 16'h3C; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0; cfg_data = '0;
    for (int i = 0; i < 3; i++) begin
      w_data = wv(16'h10 * 16'(i + 1)); w_vld = 2'b11;
      tick();
      w_vld = '0;
      chk("stk_r_vld", 160'(r_vld), 160'(2'b11));
      chk("stk_r_data", 160'(r_data), 160'(mk(16'h10 * 16'(i + 1), 16'h3C)));
      r_done = 2'b11;
      tick();
      r_done = '0;
      chk("stk_rel_r_vld", 160'(r_vld), 160'(2'b00));
      chk("stk_rel_cfg_rdy", 160'(cfg_rdy), 160'(1'b1));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
